// File: rtl/packet_parser.sv
// Byte-stream packet parser: PREFIX, SRC, DST, LEN, payload, CRC (sum of payload),
// then replays the payload to channel DST. Optional inter-byte timeout: PARSER_TIMEOUT_EN.
module packet_parser #(
  parameter int         N_SRC       = 8,
  parameter logic [7:0] PREFIX      = 8'hDD,
  parameter int         TIMEOUT_CYC = 48000
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       master_data,
  output logic [N_SRC-1:0] valid_bus,
  input  logic             master_ready,
  output logic [7:0]       src_addr,
  output logic             pkt_ok,
  output logic             crc_err,
  output logic             addr_err,
  output logic             tout_err,
  output logic             overrun,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_SRC, S_DST, S_LEN, S_PAYLOAD, S_CHK, S_EMIT
  } state_t;

  // Handshake: a payload byte is transferred on every clk edge where
  // valid_bus != 0 and master_ready is high; otherwise byte and strobe hold.

  state_t           state_q;
  logic [7:0]       src_q, src_addr_q, dst_q, len_q, idx_q, sum_q, md_q;
  logic [N_SRC-1:0] vb_q;
  logic             pkt_ok_q, crc_err_q, addr_err_q, overrun_q;
  logic [7:0]       mem_q [256];
  logic [N_SRC-1:0] dst_hot;
  logic             dst_ok, wr_en, tout_hit;

  assign dst_ok = ({24'd0, dst_q} < 32'(N_SRC));
  assign wr_en  = (state_q == S_PAYLOAD) && rx_valid;

  always_comb begin
    dst_hot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (dst_q == 8'(i)) dst_hot[i] = 1'b1;
    end
  end

  // Payload store has no reset; contents are don't-care until rewritten.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx_q] <= rx_data;
  end

`ifdef PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt_q;
  logic          tout_err_q;
  logic          counting;

  assign counting = (state_q == S_SRC) || (state_q == S_DST) || (state_q == S_LEN) ||
                    (state_q == S_PAYLOAD) || (state_q == S_CHK);
  assign tout_hit = counting && !rx_valid && (tcnt_q == TW'(TIMEOUT_CYC - 1));
  assign tout_err = tout_err_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tcnt_q <= '0;
    end else if (!counting || rx_valid || tout_hit) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end
`else
  assign tout_hit = 1'b0;
  assign tout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      src_addr_q <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      md_q       <= '0;
      vb_q       <= '0;
      pkt_ok_q   <= 1'b0;
      crc_err_q  <= 1'b0;
      addr_err_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef PARSER_TIMEOUT_EN
      tout_err_q <= 1'b0;
`endif
    end else begin
      pkt_ok_q   <= 1'b0;
      crc_err_q  <= 1'b0;
      addr_err_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef PARSER_TIMEOUT_EN
      tout_err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (rx_valid && rx_data == PREFIX) state_q <= S_SRC;
        end
        S_SRC: begin
          if (rx_valid) begin
            src_q   <= rx_data;
            state_q <= S_DST;
          end
        end
        S_DST: begin
          if (rx_valid) begin
            dst_q      <= rx_data;
            src_addr_q <= src_q;
            state_q    <= S_LEN;
          end
        end
        S_LEN: begin
          if (rx_valid) begin
            len_q   <= rx_data;
            idx_q   <= '0;
            sum_q   <= '0;
            state_q <= (rx_data == 8'd0) ? S_CHK : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (rx_valid) begin
            sum_q <= sum_q + rx_data;
            idx_q <= idx_q + 8'd1;
            if (idx_q == len_q - 8'd1) state_q <= S_CHK;
          end
        end
        S_CHK: begin
          if (rx_valid) begin
            idx_q <= '0;
            if (rx_data != sum_q) begin
              crc_err_q <= 1'b1;
              state_q   <= S_IDLE;
            end else if (!dst_ok) begin
              addr_err_q <= 1'b1;
              state_q    <= S_IDLE;
            end else if (len_q == 8'd0) begin
              pkt_ok_q <= 1'b1;
              state_q  <= S_IDLE;
            end else begin
              state_q <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (rx_valid) overrun_q <= 1'b1;
          // First EMIT cycle only loads byte 0; afterwards the strobe stays up until the last accept.
          if (vb_q == '0) begin
            md_q <= mem_q[idx_q];
            vb_q <= dst_hot;
          end else if (master_ready) begin
            if (idx_q == len_q - 8'd1) begin
              md_q     <= '0;
              vb_q     <= '0;
              idx_q    <= '0;
              pkt_ok_q <= 1'b1;
              state_q  <= S_IDLE;
            end else begin
              md_q  <= mem_q[idx_q + 8'd1];
              idx_q <= idx_q + 8'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
`ifdef PARSER_TIMEOUT_EN
      if (tout_hit) begin
        tout_err_q <= 1'b1;
        state_q    <= S_IDLE;
      end
`endif
    end
  end

  assign master_data = md_q;
  assign valid_bus   = vb_q;
  assign src_addr    = src_addr_q;
  assign pkt_ok      = pkt_ok_q;
  assign crc_err     = crc_err_q;
  assign addr_err    = addr_err_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: doc/packet_parser.md
PACKET_PARSER -- requirements
Module: packet_parser

Interface
REQ-001 SHALL have parameter N_SRC, default 8: number of destination channels, the width of valid_bus.
REQ-002 SHALL have parameter PREFIX, default 8'hDD: start-of-packet byte.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 48000: inter-byte timeout, 1 ms at 48 MHz.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port n_rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port rx_data, input, 8: byte from the UART receiver.
REQ-007 SHALL have port rx_valid, input, 1: one-cycle strobe qualifying rx_data.
REQ-008 SHALL have port master_data, output, 8: payload byte toward the destination channels.
REQ-009 SHALL have port valid_bus, output, N_SRC: one-hot strobe; bit [dest] qualifies master_data.
REQ-010 SHALL have port master_ready, input, 1: downstream accepts the byte when high.
REQ-011 SHALL have port src_addr, output, 8: source address of the packet being emitted.
REQ-012 SHALL have port pkt_ok, output, 1: one-cycle pulse after the last payload byte is accepted.
REQ-013 SHALL have port crc_err, output, 1: one-cycle pulse on CRC mismatch.
REQ-014 SHALL have port addr_err, output, 1: one-cycle pulse when dest >= N_SRC.
REQ-015 SHALL have port tout_err, output, 1: one-cycle pulse on inter-byte timeout.
REQ-016 SHALL have port overrun, output, 1: one-cycle pulse when rx_valid arrives during EMIT.
REQ-017 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-018 SHALL accept the frame format PREFIX, SRC, DST, LEN, LEN payload bytes, CRC.
REQ-019 SHALL define CRC as the 8-bit sum, modulo 256, of the payload bytes only; LEN=0 requires CRC=8'h00.
REQ-020 SHALL use the FSM states IDLE, SRC, DST, LEN, PAYLOAD, CHK, EMIT; each byte-driven transition occurs on the rx_valid cycle.
REQ-021 SHALL stay in IDLE and silently discard any byte other than PREFIX.
REQ-022 SHALL, on LEN=0, go from LEN directly to CHK.
REQ-023 SHALL, in PAYLOAD, write each byte to an internal 256x8 buffer at an index counting 0..LEN-1, accumulate the sum, and enter CHK after byte LEN-1.
REQ-024 SHALL, in CHK, on the CRC byte compare the received CRC with the sum.
REQ-025 SHALL, on CRC mismatch, pulse crc_err on the next cycle and return to IDLE.
REQ-026 SHALL, on CRC match with dest >= N_SRC, pulse addr_err and return to IDLE.
REQ-027 SHALL, on CRC match with valid dest and LEN=0, pulse pkt_ok and return to IDLE.
REQ-028 SHALL, on CRC match with valid dest and LEN>0, enter EMIT.
REQ-029 SHALL, in EMIT, present buffer bytes in order on master_data with valid_bus[dest] high, holding the byte and strobe while master_ready is low.
REQ-030 SHALL advance one byte per cycle in EMIT while master_ready is high; the first byte appears on the cycle after EMIT entry.
REQ-031 SHALL pulse pkt_ok on the cycle after the last byte is accepted and return to IDLE.
REQ-032 SHALL hold src_addr stable from the DST byte until the next PREFIX is accepted.
REQ-033 SHALL, in EMIT, drop incoming rx_valid bytes and pulse overrun for each one; the FSM stays in EMIT.
REQ-034 SHALL drive valid_bus to all zeros in every state except EMIT.
REQ-035 SHALL never drive more than one valid_bus bit at a time.

Reset
REQ-036 SHALL, when n_rst is low at any time, including mid-packet or mid-EMIT, immediately force the FSM to IDLE, the index and sum to 0, and all outputs to 0.
REQ-037 SHALL leave the buffer contents undefined after reset; the buffer is not cleared.

Configuration
REQ-038 SHALL, when PARSER_TIMEOUT_EN is defined, count cycles since the last rx_valid in states SRC..CHK.
REQ-039 SHALL, when PARSER_TIMEOUT_EN is defined and the count reaches TIMEOUT_CYC, pulse tout_err and return to IDLE; the counter is cleared by every rx_valid and in IDLE and EMIT.
REQ-040 SHALL, when PARSER_TIMEOUT_EN is undefined, build no counter, tie tout_err to 0, and wait indefinitely for each byte.

Verification
REQ-041 SHALL verify: DD 01 02 06 01 02 03 04 05 06 15 with master_ready=1 -> valid_bus=8'h04 for 6 consecutive cycles, master_data 01..06, src_addr=01, then pkt_ok.
REQ-042 SHALL verify: same frame with CRC=14 -> crc_err once, valid_bus stays 0, busy falls.
REQ-043 SHALL verify: DD 01 09 01 AA AA (N_SRC=8) -> addr_err once, no valid_bus activity.
REQ-044 SHALL verify: DD 03 00 00 00 -> pkt_ok without any valid_bus strobe; 55 DD 01 02 00 00 -> the leading 55 is ignored and pkt_ok follows.
REQ-045 SHALL verify: valid frame with master_ready toggling 1,0,0,1 -> each byte is held while ready is low and no byte is lost or duplicated; n_rst pulsed mid-EMIT -> all outputs 0 at once and a following frame parses correctly.
REQ-046 SHALL verify, with PARSER_TIMEOUT_EN defined: DD 01 then a 60000-cycle gap -> tout_err once after 48000 cycles; the next full frame parses correctly.
